// File: rtl/decode_pkg.sv
// Shared decode types: opcode classes, instruction field positions and the decoded entry layout.
package decode_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_LSB = 20;
  localparam int RN_MSB    = 19;
  localparam int RN_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 12;
  localparam int RM_MSB    = 3;
  localparam int RM_LSB    = 0;
  localparam int BR_OFF_MSB = 23;

  localparam logic [3:0] REG_PC = 4'hF;

  // Immediate is kept outside the struct so its width can follow the BITS parameter.
  typedef struct packed {
    logic [3:0] cond;
    op_e        op;
    logic [5:0] funct;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction splitter: fields, per-class register ports and resolved immediate.
// Zero latency, no flow control; sits on the queue write path.
module decode_fields
  import decode_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] i_instr,
  output decoded_t        o_dec,
  output logic [BITS-1:0] o_imm
);

  op_e w_op;

  assign w_op = op_e'(i_instr[OP_MSB:OP_LSB]);

  always_comb begin
    o_dec         = '0;
    o_dec.cond    = i_instr[COND_MSB:COND_LSB];
    o_dec.op      = w_op;
    o_dec.funct   = i_instr[FUNCT_MSB:FUNCT_LSB];
    o_dec.ra1     = (w_op == OP_BR)  ? REG_PC : i_instr[RN_MSB:RN_LSB];
    // Stores read their data register through the second port.
    o_dec.ra2     = (w_op == OP_MEM) ? i_instr[RD_MSB:RD_LSB] : i_instr[RM_MSB:RM_LSB];
    o_dec.wa3     = i_instr[RD_MSB:RD_LSB];
    o_dec.illegal = (w_op == OP_ILL);
  end

  always_comb begin
    o_imm = '0;
    case (w_op)
      OP_DP:   o_imm = {{(BITS-8){1'b0}}, i_instr[7:0]};
      OP_MEM:  o_imm = {{(BITS-12){1'b0}}, i_instr[11:0]};
      OP_BR:   o_imm = {{(BITS-26){i_instr[BR_OFF_MSB]}}, i_instr[BR_OFF_MSB:0], 2'b00};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on push, queues DEPTH entries, presents the head one cycle later.
// Optional DECODE_PERF_EN adds a saturating stall counter on stall_cnt_o (tied to 0 otherwise).
module decode_stage
  import decode_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  input  logic [BITS-1:0] instr_i,
  output logic            instr_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [1:0]      op_o,
  output logic [5:0]      funct_o,
  output logic [3:0]      cond_o,
  output logic [3:0]      ra1_o,
  output logic [3:0]      ra2_o,
  output logic [3:0]      wa3_o,
  output logic [BITS-1:0] imm_o,
  output logic            illegal_o,
  output logic [31:0]     stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  decoded_t        r_mem     [DEPTH];
  logic [BITS-1:0] r_imm_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  decoded_t        r_last_dec;
  logic [BITS-1:0] r_last_imm;

  decoded_t        w_dec, w_head_dec;
  logic [BITS-1:0] w_imm, w_head_imm;
  logic            w_full, w_empty, w_push, w_pop;

  decode_fields #(.BITS(BITS)) u_fields (
    .i_instr (instr_i),
    .o_dec   (w_dec),
    .o_imm   (w_imm)
  );

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = instr_valid_i && !w_full && !flush_i;
  assign w_pop   = !w_empty && out_ready_i && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]     <= '0;
        r_imm_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]     <= w_dec;
        r_imm_mem[r_wr_ptr] <= w_imm;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When empty the outputs show the most recent head rather than a stale slot.
  assign w_head_dec = w_empty ? r_last_dec : r_mem[r_rd_ptr];
  assign w_head_imm = w_empty ? r_last_imm : r_imm_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dec <= '0;
      r_last_imm <= '0;
    end else begin
      r_last_dec <= w_head_dec;
      r_last_imm <= w_head_imm;
    end
  end

  assign instr_ready_o = !w_full;
  assign out_valid_o   = !w_empty;
  assign op_o          = w_head_dec.op;
  assign funct_o       = w_head_dec.funct;
  assign cond_o        = w_head_dec.cond;
  assign ra1_o         = w_head_dec.ra1;
  assign ra2_o         = w_head_dec.ra2;
  assign wa3_o         = w_head_dec.wa3;
  assign illegal_o     = w_head_dec.illegal;
  assign imm_o         = w_head_imm;

`ifdef DECODE_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (instr_valid_i && w_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus hand-written queue/flush/reset sequences.
module tb_decode_stage;

  localparam int BITS  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            instr_valid_i = 1'b0;
  logic [BITS-1:0] instr_i = '0;
  logic            instr_ready_o;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [1:0]      op_o;
  logic [5:0]      funct_o;
  logic [3:0]      cond_o;
  logic [3:0]      ra1_o;
  logic [3:0]      ra2_o;
  logic [3:0]      wa3_o;
  logic [BITS-1:0] imm_o;
  logic            illegal_o;
  logic [31:0]     stall_cnt_o;

  decode_stage #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .op_o          (op_o),
    .funct_o       (funct_o),
    .cond_o        (cond_o),
    .ra1_o         (ra1_o),
    .ra2_o         (ra2_o),
    .wa3_o         (wa3_o),
    .imm_o         (imm_o),
    .illegal_o     (illegal_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [56:0] exp;
  } vec_t;

  vec_t        vt [8];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [56:0] w_act;
  logic [31:0] exp_stall;

  assign w_act = {op_o, funct_o, cond_o, ra1_o, ra2_o, wa3_o, illegal_o, imm_o};

  function automatic logic [56:0] pk(input logic [1:0] op, input logic [5:0] funct,
                                     input logic [3:0] cond, input logic [3:0] ra1,
                                     input logic [3:0] ra2, input logic [3:0] wa3,
                                     input logic ill, input logic [31:0] imm);
    return {op, funct, cond, ra1, ra2, wa3, ill, imm};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    //               instr                op     funct  cond  ra1   ra2   wa3   ill   imm
    vt[0] = '{32'hE281_1005, pk(2'd0, 6'h28, 4'hE, 4'h1, 4'h5, 4'h1, 1'b0, 32'h0000_0005)};
    vt[1] = '{32'hEAFF_FFFE, pk(2'd2, 6'h2F, 4'hE, 4'hF, 4'hE, 4'hF, 1'b0, 32'hFFFF_FFF8)};
    vt[2] = '{32'hE580_2004, pk(2'd1, 6'h18, 4'hE, 4'h0, 4'h2, 4'h2, 1'b0, 32'h0000_0004)};
    vt[3] = '{32'h3C12_3FFF, pk(2'd3, 6'h01, 4'h3, 4'h2, 4'hF, 4'h3, 1'b1, 32'h0000_0000)};
    vt[4] = '{32'h0A00_0010, pk(2'd2, 6'h20, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 32'h0000_0040)};
    vt[5] = '{32'hE3A0_00FF, pk(2'd0, 6'h3A, 4'hE, 4'h0, 4'hF, 4'h0, 1'b0, 32'h0000_00FF)};
    vt[6] = '{32'h1407_5FFF, pk(2'd1, 6'h00, 4'h1, 4'h7, 4'h5, 4'h5, 1'b0, 32'h0000_0FFF)};
    vt[7] = '{32'h0B80_0000, pk(2'd2, 6'h38, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 32'hFE00_0000)};

    // Reset state
    #2;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_instr_ready", instr_ready_o, 1);
    chk("rst_fields", w_act, 0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode table: push one beat into an empty queue, check next cycle, pop, check hold
    for (int i = 0; i < 8; i++) begin
      instr_i = vt[i].instr;
      instr_valid_i = 1'b1;
      @(negedge clk);
      instr_valid_i = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid_o, 1);
      chk($sformatf("vec%0d_fields", i), w_act, vt[i].exp);
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk($sformatf("vec%0d_popped", i), out_valid_o, 0);
      chk($sformatf("vec%0d_hold", i), w_act, vt[i].exp);
    end

    // Fill to DEPTH, extra beat refused, drain in order
    instr_valid_i = 1'b1;
    instr_i = vt[0].instr;
    @(negedge clk);
    instr_i = vt[1].instr;
    @(negedge clk);
    chk("full_ready", instr_ready_o, 0);
    instr_i = vt[2].instr;
    @(negedge clk);
    instr_valid_i = 1'b0;
    chk("full_ready_hold", instr_ready_o, 0);
    chk("full_head_a", w_act, vt[0].exp);
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("drain_head_b", w_act, vt[1].exp);
    chk("drain_valid_b", out_valid_o, 1);
    chk("drain_ready", instr_ready_o, 1);
    @(negedge clk);
    chk("drain_empty", out_valid_o, 0);
    out_ready_i = 1'b0;

    // Full with pop and push in the same cycle: push refused, no bypass
    instr_valid_i = 1'b1;
    instr_i = vt[3].instr;
    @(negedge clk);
    instr_i = vt[4].instr;
    @(negedge clk);
    instr_i = vt[5].instr;
    out_ready_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    out_ready_i = 1'b0;
    chk("nobypass_head", w_act, vt[4].exp);
    chk("nobypass_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk("nobypass_dropped", out_valid_o, 0);

    // Simultaneous push and pop with one entry queued
    instr_valid_i = 1'b1;
    instr_i = vt[6].instr;
    @(negedge clk);
    instr_i = vt[7].instr;
    out_ready_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    chk("pushpop_head", w_act, vt[7].exp);
    chk("pushpop_valid", out_valid_o, 1);
    chk("pushpop_ready", instr_ready_o, 1);
    @(negedge clk);
    out_ready_i = 1'b0;
    chk("pushpop_empty", out_valid_o, 0);

    // Flush a full queue while a beat is offered
    instr_valid_i = 1'b1;
    instr_i = vt[0].instr;
    @(negedge clk);
    instr_i = vt[1].instr;
    @(negedge clk);
    instr_i = vt[2].instr;
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    instr_valid_i = 1'b0;
    out_ready_i = 1'b0;
    chk("flush_valid", out_valid_o, 0);
    chk("flush_ready", instr_ready_o, 1);
    chk("flush_hold", w_act, vt[0].exp);
    @(negedge clk);
    chk("flush_no_entry", out_valid_o, 0);

    // Stall counter from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_stall_cnt", stall_cnt_o, 0);
    instr_valid_i = 1'b1;
    instr_i = vt[0].instr;
    @(negedge clk);
    instr_i = vt[1].instr;
    @(negedge clk);
    instr_i = vt[2].instr;
    repeat (10) @(negedge clk);
    instr_valid_i = 1'b0;
`ifdef DECODE_PERF_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    chk("stall_10", stall_cnt_o, exp_stall);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("stall_after_flush", stall_cnt_o, exp_stall);
    chk("stall_flush_valid", out_valid_o, 0);

    // Async reset in the middle of a cycle with an entry queued
    instr_valid_i = 1'b1;
    instr_i = vt[1].instr;
    @(negedge clk);
    instr_valid_i = 1'b0;
    chk("arst_pre_valid", out_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_ready", instr_ready_o, 1);
    chk("arst_fields", w_act, 0);
    chk("arst_stall", stall_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_post_valid", out_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
